pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents a beat.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle; it is driven directly from a flop.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the block presents a beat downstream.
REQ-008 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the beat.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the payload presented downstream, driven from the main register.
REQ-010 The block SHALL have port flush, input, 1 bit: discard all held beats (pipeline flush on branch or trap).
REQ-011 The block SHALL have port count, output, 2 bits: the number of held beats, 0 to 2.

Function
REQ-012 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-013 The state machine SHALL have exactly three states: EMPTY (0 beats), ONE (main register full), TWO (main and skid registers full).
REQ-014 Outputs SHALL decode from state as follows: out_valid = (state != EMPTY); in_ready = (state != TWO), held in its own flop updated with the next state; count = 0, 1 or 2 for EMPTY, ONE or TWO.
REQ-015 In EMPTY with an input transfer, the block SHALL load in_data into main and go to ONE.
REQ-016 In ONE with an input transfer and an output transfer in the same cycle, the block SHALL load in_data into main and stay in ONE.
REQ-017 In ONE with an input transfer only, the block SHALL load in_data into skid and go to TWO.
REQ-018 In ONE with an output transfer only, the block SHALL go to EMPTY.
REQ-019 In TWO with an output transfer, the block SHALL copy skid into main and go to ONE; no input transfer is possible in TWO.
REQ-020 In any state with no transfer, the block SHALL hold its state and both registers.
REQ-021 Latency SHALL be 1 cycle from an input transfer into EMPTY to out_valid=1 with that data.
REQ-022 Sustained throughput SHALL be 1 beat per cycle while out_ready=1.
REQ-023 Beats SHALL leave in the order they were accepted; no beat is dropped or duplicated except by flush.
REQ-024 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-025 flush=1 SHALL force the next state to EMPTY and in_ready to 1, taking priority over any simultaneous transfer.
REQ-026 Under flush, an in_valid beat in the same cycle SHALL be discarded, and the downstream SHALL treat the flush cycle's output transfer as squashed.
REQ-027 Register contents need not be cleared on flush; out_data is don't-care while out_valid=0.
REQ-028 out_ready SHALL be ignored in EMPTY.
REQ-029 in_data SHALL be ignored when in_ready=0.

Reset
REQ-030 While rst=1, regardless of clk, the block SHALL drive state=EMPTY, out_valid=0, in_ready=1, count=0, main=0, skid=0.
REQ-031 rst asserted mid-operation, including in TWO, SHALL discard all held beats immediately.
REQ-032 The first transfer after reset SHALL be accepted on the first rising clk edge with rst=0 and in_valid=1.

Verification
REQ-033 Reset then pass-through: in_valid=1 with 0x11, 0x22, 0x33 on consecutive cycles and out_ready=1 -> out_data shows 0x11, 0x22, 0x33 one cycle later each, and in_ready stays 1.
REQ-034 Backpressure: with out_ready=0, send 0xA then 0xB -> count=2, in_ready=0 and out_data=0xA held; then out_ready=1 -> 0xA, then 0xB, then out_valid=0.
REQ-035 Simultaneous transfers in ONE (main=0x5, in_data=0x6, out_ready=1) -> 0x5 leaves, main=0x6, count stays 1.
REQ-036 flush in TWO with in_valid=1 (0x7) -> next cycle count=0, out_valid=0, in_ready=1, and 0x7 never appears.
REQ-037 Async reset mid-cycle in TWO -> outputs at reset values before the next clk edge, and no stale beat after release.
REQ-038 Randomized valid/ready for 10k cycles against a reference queue -> order preserved, count always <= 2, and out_data stable under stall.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages: main register feeds downstream,
// skid register catches the beat accepted while the downstream stalls.
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    count = 2'd0;
    case (state)
      ONE:     count = 2'd1;
      TWO:     count = 2'd2;
      default: count = 2'd0;
    endcase
  end

  // in_ready is its own flop, written alongside every state change so it
  // always equals (state != TWO) without a combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (in_xfer) begin
            skid_q   <= in_data;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table, async-reset sequence and a randomized run checked
// against a reference queue for pipe_skid_reg.
module tb_pipe_skid_reg;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       count;

  int checks = 0;
  int errors = 0;

  pipe_skid_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        ov;
    logic        ir;
    logic [1:0]  cnt;
    logic        chk_d;
    logic [31:0] dat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic fl, input logic ov, input logic ir,
                              input logic [1:0] cnt, input logic chk_d, input logic [31:0] dat);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.ir = ir; v.cnt = cnt; v.chk_d = chk_d; v.dat = dat;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic ir,
                            input logic [1:0] cnt, input logic chk_d, input logic [31:0] dat);
    check({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    check({tag, " count"}, {30'd0, count}, {30'd0, cnt});
    if (chk_d) check({tag, " out_data"}, out_data, dat);
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  logic [31:0] q[$];
  logic        r_iv, r_or, r_fl;
  logic [31:0] r_d;

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_outs("reset", 1'b0, 1'b1, 2'd0, 1'b1, 32'h0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // pass-through
    add(1, 32'h11, 1, 0,  1, 1, 2'd1, 1, 32'h11);
    add(1, 32'h22, 1, 0,  1, 1, 2'd1, 1, 32'h22);
    add(1, 32'h33, 1, 0,  1, 1, 2'd1, 1, 32'h33);
    add(0, 32'h00, 1, 0,  0, 1, 2'd0, 0, 32'h0);
    // backpressure, third beat ignored while full
    add(1, 32'h0A, 0, 0,  1, 1, 2'd1, 1, 32'h0A);
    add(1, 32'h0B, 0, 0,  1, 0, 2'd2, 1, 32'h0A);
    add(1, 32'h0C, 0, 0,  1, 0, 2'd2, 1, 32'h0A);
    add(0, 32'h00, 1, 0,  1, 1, 2'd1, 1, 32'h0B);
    add(0, 32'h00, 1, 0,  0, 1, 2'd0, 0, 32'h0);
    // simultaneous transfers in ONE
    add(1, 32'h05, 0, 0,  1, 1, 2'd1, 1, 32'h05);
    add(1, 32'h06, 1, 0,  1, 1, 2'd1, 1, 32'h06);
    add(0, 32'h00, 1, 0,  0, 1, 2'd0, 0, 32'h0);
    // flush in TWO with a beat offered
    add(1, 32'h08, 0, 0,  1, 1, 2'd1, 1, 32'h08);
    add(1, 32'h09, 0, 0,  1, 0, 2'd2, 1, 32'h08);
    add(1, 32'h07, 1, 1,  0, 1, 2'd0, 0, 32'h0);
    add(0, 32'h00, 1, 0,  0, 1, 2'd0, 0, 32'h0);
    add(1, 32'h44, 0, 0,  1, 1, 2'd1, 1, 32'h44);
    add(0, 32'h00, 1, 0,  0, 1, 2'd0, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].cnt,
                 vecs[i].chk_d, vecs[i].dat);
    end

    // async reset while in TWO
    @(negedge clk); drive(1, 32'hA1, 0, 0);
    @(negedge clk); drive(1, 32'hA2, 0, 0);
    @(negedge clk); drive(0, 32'h0, 0, 0);
    #1;
    check_outs("pre_rst", 1'b1, 1'b0, 2'd2, 1'b1, 32'hA1);
    #1;
    rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 1'b1, 2'd0, 1'b1, 32'h0);
    #10;
    rst = 1'b0;
    @(negedge clk); drive(0, 32'h0, 1, 0);
    @(posedge clk); #1;
    check_outs("post_rst_idle", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);
    @(negedge clk); drive(1, 32'h55, 0, 0);
    @(posedge clk); #1;
    check_outs("post_rst_first", 1'b1, 1'b1, 2'd1, 1'b1, 32'h55);
    @(negedge clk); drive(0, 32'h0, 1, 0);
    @(posedge clk); #1;
    check_outs("post_rst_drain", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0);

    // randomized traffic against a reference queue
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          count !== 2'(q.size()) || (q.size() > 0 && out_data !== q[0])) begin
        errors++;
        $display("FAIL rand cyc%0d actual ov=%0b ir=%0b cnt=%0d data=%0h expected size=%0d head=%0h",
                 c, out_valid, in_ready, count, out_data, q.size(),
                 (q.size() > 0) ? q[0] : 32'h0);
      end
      r_iv = 1'($urandom_range(0, 1));
      r_or = 1'($urandom_range(0, 1));
      r_fl = ($urandom_range(0, 63) == 0);
      r_d  = $urandom;
      drive(r_iv, r_d, r_or, r_fl);
      if (r_fl) begin
        q.delete();
      end else begin
        logic ix, ox;
        ix = r_iv && (q.size() < 2);
        ox = r_or && (q.size() > 0);
        if (ox) void'(q.pop_front());
        if (ix) q.push_back(r_d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
